// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the multiplier FSM state type, the twiddle table
// used by the base-case multiplier, and the modular reduction helper.
package kyber_pkg;

   localparam int N  = 256;
   localparam int Q  = 3329;
   localparam int CW = 12;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_e;

   // gamma_i = 17^(2*BitRev7(i)+1) mod Q; each odd entry is Q minus the even one before it
   localparam logic [CW-1:0] GAMMA [0:127] = '{
      17, 3312, 2761, 568, 583, 2746, 2649, 680, 1637, 1692, 723, 2606, 2288, 1041, 1100, 2229,
      1409, 1920, 2662, 667, 3281, 48, 233, 3096, 756, 2573, 2156, 1173, 3015, 314, 3050, 279,
      1703, 1626, 1651, 1678, 2789, 540, 1789, 1540, 1847, 1482, 952, 2377, 1461, 1868, 2687, 642,
      939, 2390, 2308, 1021, 2437, 892, 2388, 941, 733, 2596, 2337, 992, 268, 3061, 641, 2688,
      1584, 1745, 2298, 1031, 2037, 1292, 3220, 109, 375, 2954, 2549, 780, 2090, 1239, 1645, 1684,
      1063, 2266, 319, 3010, 2773, 556, 757, 2572, 2099, 1230, 561, 2768, 2466, 863, 2594, 735,
      2804, 525, 1092, 2237, 403, 2926, 1026, 2303, 1143, 2186, 2150, 1179, 2775, 554, 886, 2443,
      1722, 1607, 1212, 2117, 1874, 1455, 1029, 2300, 2110, 1219, 2935, 394, 885, 2444, 2154, 1175
   };

   function automatic logic [CW-1:0] reduce_q(input logic signed [31:0] x, input int q);
      logic signed [31:0] r;
      r = x % q;
      // The remainder takes the sign of x, so fold negatives into [0, q-1]
      if (r < 0) r = r + q;
      return CW'(r);
   endfunction

endpackage

// File: rtl/base_case_multiply.sv
// Kyber base-case multiply of two degree-1 polynomials modulo (X^2 - gamma).
// Purely combinational; products stay full width until the final reduction.
module base_case_multiply #(
   parameter int Q = kyber_pkg::Q
) (
   input  logic [kyber_pkg::CW-1:0] a0,
   input  logic [kyber_pkg::CW-1:0] a1,
   input  logic [kyber_pkg::CW-1:0] b0,
   input  logic [kyber_pkg::CW-1:0] b1,
   input  logic [kyber_pkg::CW-1:0] gamma,
   output logic [kyber_pkg::CW-1:0] c0,
   output logic [kyber_pkg::CW-1:0] c1
);
   import kyber_pkg::*;

   localparam int PW = 2 * CW;
   localparam logic [PW-1:0] Q_P = PW'(Q);
   localparam logic [PW:0]   Q_S = (PW + 1)'(Q);

   logic [PW-1:0] p00, p11, p01, p10, p11g;
   logic [CW-1:0] p11_r;
   logic [PW:0]   s0, s1;

   always_comb begin
      p00   = PW'(a0) * PW'(b0);
      p11   = PW'(a1) * PW'(b1);
      p01   = PW'(a0) * PW'(b1);
      p10   = PW'(a1) * PW'(b0);
      // a1*b1 is reduced before the gamma multiply so that product also fits PW bits
      p11_r = CW'(p11 % Q_P);
      p11g  = PW'(p11_r) * PW'(gamma);
      s0    = {1'b0, p00} + {1'b0, p11g};
      s1    = {1'b0, p01} + {1'b0, p10};
      c0    = CW'(s0 % Q_S);
      c1    = CW'(s1 % Q_S);
   end

endmodule

// File: rtl/multiply_ntts.sv
// Kyber MultiplyNTTs: captures two NTT-domain polynomials, then produces one
// coefficient pair per clock through a single time-shared base-case multiplier.
module multiply_ntts #(
   parameter int N = kyber_pkg::N,
   parameter int Q = kyber_pkg::Q
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [31:0] f_hat [0:N-1],
   input  logic signed [31:0] g_hat [0:N-1],
   input  logic               start_mul,
   output logic               done_mul,
   output logic signed [31:0] h_hat [0:N-1]
);
   import kyber_pkg::*;

   localparam int            IW   = $clog2(N / 2);
   localparam logic [IW-1:0] LAST = IW'(N / 2 - 1);

   state_e        state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic          cap_en, wr_en;
   logic [CW-1:0] f_cap [0:N-1];
   logic [CW-1:0] g_cap [0:N-1];
   logic [CW-1:0] c0, c1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         i_q     <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      cap_en   = 1'b0;
      wr_en    = 1'b0;
      done_mul = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_mul) begin
               cap_en  = 1'b1;
               i_d     = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            wr_en = 1'b1;
            // The last pair leaves i parked instead of wrapping back to zero
            if (i_q == LAST) state_d = DONE;
            else             i_d     = i_q + IW'(1);
         end
         DONE: begin
            done_mul = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   base_case_multiply #(.Q(Q)) u_bcm (
      .a0    (f_cap[{i_q, 1'b0}]),
      .a1    (f_cap[{i_q, 1'b1}]),
      .b0    (g_cap[{i_q, 1'b0}]),
      .b1    (g_cap[{i_q, 1'b1}]),
      .gamma (GAMMA[i_q]),
      .c0    (c0),
      .c1    (c1)
   );

   for (genvar k = 0; k < N; k++) begin : g_coef
      logic [CW-1:0] f_q, g_q, h_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            f_q <= '0;
            g_q <= '0;
         end else if (cap_en) begin
            f_q <= reduce_q(f_hat[k], Q);
            g_q <= reduce_q(g_hat[k], Q);
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            h_q <= '0;
         end else if (wr_en && (i_q == IW'(k / 2))) begin
            h_q <= (k % 2 == 0) ? c0 : c1;
         end
      end

      assign f_cap[k] = f_q;
      assign g_cap[k] = g_q;
      assign h_hat[k] = {{(32 - CW){1'b0}}, h_q};
   end

endmodule
